// File: rtl/if_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam logic [31:0] PC_INC   = 32'd4;

  typedef enum logic [1:0] {
    StBoot   = 2'd0,
    StRun    = 2'd1,
    StHalted = 2'd2
  } if_state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{inst: NOP_INST, pc4: 32'h0, valid: 1'b0};

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats load, otherwise hold.
module if_id_reg
  import if_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic        i_flush,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc4,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc4,
  output logic        o_valid
);

  if_id_t r_if_id;

  // Synchronous reset, then flush / load / hold.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_if_id <= IF_ID_BUBBLE;
    end else if (i_flush) begin
      r_if_id <= IF_ID_BUBBLE;
    end else if (i_load) begin
      r_if_id <= '{inst: i_inst, pc4: i_pc4, valid: 1'b1};
    end
  end

  assign o_inst  = r_if_id.inst;
  assign o_pc4   = r_if_id.pc4;
  assign o_valid = r_if_id.valid;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, BOOT/RUN/HALTED control and next-PC mux.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IMEM_AW  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] IM_addr,
  input  logic [31:0] inst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        halt_req,
  input  logic        resume,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        misalign_err,
  output logic        oob_err
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  if_state_t   r_state;
  if_state_t   w_state_d;
  logic [31:0] r_pc;
  logic [31:0] w_pc_d;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_redir_pc;
  logic        w_fetch;
  logic        w_flush;
  logic        w_oob;
  logic        r_misalign;
  logic        r_oob;

  assign w_pc_plus4 = r_pc + PC_INC;
  assign w_redir_pc = {redirect_target[31:2], 2'b00};
  assign w_oob      = |r_pc[31:IMEM_AW];

  // Next-state / next-PC decode; redirect beats halt beats stall beats sequential.
  always_comb begin
    w_state_d = r_state;
    w_pc_d    = r_pc;
    w_fetch   = 1'b0;
    w_flush   = 1'b0;
    unique case (r_state)
      StBoot: begin
        w_flush   = 1'b1;
        w_state_d = StRun;
      end
      StRun: begin
        if (redirect_valid) begin
          w_pc_d  = w_redir_pc;
          w_flush = 1'b1;
          if (halt_req) w_state_d = StHalted;
        end else if (halt_req) begin
          w_flush   = 1'b1;
          w_state_d = StHalted;
        end else if (!stall) begin
          w_fetch = 1'b1;
          w_pc_d  = w_pc_plus4;
        end
      end
      StHalted: begin
        w_flush = 1'b1;
        if (redirect_valid) w_pc_d = w_redir_pc;
        if (resume) w_state_d = StRun;
      end
      default: begin
        w_flush   = 1'b1;
        w_state_d = StBoot;
      end
    endcase
  end

  // PC, FSM and registered error flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= StBoot;
      r_pc       <= RESET_PC;
      r_misalign <= 1'b0;
      r_oob      <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_pc       <= w_pc_d;
      r_misalign <= redirect_valid && (redirect_target[1:0] != 2'b00) && (r_state != StBoot);
      if (w_fetch) r_oob <= w_oob;
    end
  end

  if_id_reg u_if_id_reg (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_load  (w_fetch),
    .i_flush (w_flush),
    .i_inst  (inst),
    .i_pc4   (w_pc_plus4),
    .o_inst  (if_id_inst),
    .o_pc4   (if_id_pc4),
    .o_valid (if_id_valid)
  );

  assign IM_addr      = r_pc;
  assign misalign_err = r_misalign;
  assign oob_err      = r_oob;

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  // Counters only advance in RUN; they wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_fetch) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if ((r_state == StRun) && stall && !redirect_valid) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt = r_fetch_cnt;
  assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage that sits directly upstream of the byte-addressed, little-endian combinational instruction memory.
- Owns the program counter and drives the memory address.
- Captures the returned 32-bit word into the IF/ID pipeline register for the decoder.
- Handles stall, redirect (branch/jump) with wrong-path flush, and a halt/resume control FSM.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset.
IMEM_AW, 8, byte-address width actually decoded by instruction memory; used only for the out-of-range flag.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
IM_addr  output  32  byte address to instruction memory; equals current PC (combinational from PC register).
inst  input  32  instruction word returned combinationally by instruction memory for IM_addr.
stall  input  1  hazard-unit hold request; freezes PC and IF/ID.
redirect_valid  input  1  branch taken / jump resolved downstream this cycle.
redirect_target  input  32  new PC for redirect.
halt_req  input  1  enter HALTED state.
resume  input  1  leave HALTED state.
if_id_inst  output  32  registered instruction to decode.
if_id_pc4  output  32  registered PC+4 of that instruction.
if_id_valid  output  1  IF/ID holds a real (non-bubble) instruction.
misalign_err  output  1  one-cycle pulse: redirect_target[1:0] != 0.
oob_err  output  1  registered: PC[31:IMEM_AW] != 0 when fetched.

Behaviour:
- Reset (rst_n=0 at edge):
  - PC=RESET_PC, state=BOOT.
  - if_id_inst=32'h0 (NOP), if_id_pc4=0, if_id_valid=0.
  - misalign_err=0, oob_err=0.
- FSM states: BOOT, RUN, HALTED.
  - BOOT: one cycle after reset release; no fetch, IF/ID bubble; unconditionally -> RUN.
  - RUN: fetch each cycle per rules below; halt_req=1 -> HALTED.
  - HALTED: PC frozen, IF/ID loaded with bubble every cycle; resume=1 -> RUN next cycle.
  - halt_req and resume both 1 in HALTED: resume wins.
  - halt_req and resume both 1 in RUN: halt wins.
  - redirect_valid in HALTED: PC updated to target, state stays HALTED.
- RUN update priority per cycle: redirect > stall > sequential.
  - Redirect:
    - PC <= {redirect_target[31:2],2'b00}.
    - IF/ID <= bubble (inst=0, valid=0), flushing the wrong-path word.
    - Applies even if stall=1 the same cycle.
  - Stall (no redirect): PC, if_id_* and oob_err hold their values.
  - Sequential:
    - PC <= PC+4, wrapping modulo 2^32.
    - if_id_inst <= inst, if_id_pc4 <= PC+4, if_id_valid <= 1.
    - oob_err <= |PC[31:IMEM_AW].
- Fetch latency: word at PC appears on if_id_inst one clock after PC is presented.
- misalign_err: registered, 1 for exactly one cycle after any cycle with redirect_valid=1 and redirect_target[1:0]!=0, in any state except BOOT; otherwise 0.
- Reset mid-operation: the reset values above apply at the next edge regardless of state, stall or redirect.

Optional Feature:
IF_PERF_CNT_EN
- Defined:
  - Adds outputs perf_fetch_cnt[31:0] (increments on each sequential fetch) and perf_stall_cnt[31:0] (increments each RUN cycle with stall=1 and redirect_valid=0).
  - Both counters reset to 0, wrap at 2^32, and are frozen in BOOT/HALTED.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package if_pkg:
  - NOP_INST = 32'h0000_0000.
  - PC_INC = 32'd4.
  - FSM state encoding (BOOT=2'd0, RUN=2'd1, HALTED=2'd2).
  - Bubble constant for the IF/ID bundle.
- One sub-module, if_id_reg: IF/ID register with load/hold/flush controls.
- Top-level block holds PC, FSM and next-PC mux.

Test Plan:
- Reset then free-run, memory preloaded with words 0x11111111, 0x22222222, 0x33333333 at 0x0/0x4/0x8 -> IM_addr 0x0 held through BOOT; if_id_inst sequence 0x11111111, 0x22222222, 0x33333333 with if_id_pc4 0x4, 0x8, 0xC and valid=1.
- stall=1 for 2 cycles at PC=0x8 -> IM_addr stays 0x8, if_id_inst stays 0x22222222; resumes with 0x33333333.
- redirect_valid=1, target=0x40, same cycle as stall=1 -> next IM_addr=0x40; if_id_valid=0 and if_id_inst=0 for one cycle; then word at 0x40 with pc4=0x44.
- redirect target=0x43 -> PC=0x40, misalign_err high exactly one cycle.
- halt_req pulse at PC=0x10, resume after 3 cycles -> IM_addr frozen at 0x10, if_id_valid=0 while halted, fetch of 0x10 follows resume; PC=0x100 fetch -> oob_err=1 with IMEM_AW=8.
- rst_n=0 mid-stream with stall=1 and redirect_valid=1 -> next edge: PC=RESET_PC, all if_id_* and error outputs 0, state BOOT; with IF_PERF_CNT_EN both counters read 0.
